// File: rtl/op_dispatch_pkg.sv
// Shared definitions for the operation dispatcher: descriptor layout and FSM state codes.
// Descriptor packs cmd, param and length in the low bytes, followed by left/right/top/bottom.
package op_dispatch_pkg;

   localparam int OPD_FIELD_W   = 8;
   localparam int OPD_CMD_LSB   = 0;
   localparam int OPD_PARAM_LSB = 8;
   localparam int OPD_LEN_LSB   = 16;
   localparam int OPD_RECT_LSB  = 24;

   localparam logic [1:0] OPD_IDLE   = 2'd0;
   localparam logic [1:0] OPD_LOAD   = 2'd1;
   localparam logic [1:0] OPD_ARM    = 2'd2;
   localparam logic [1:0] OPD_ACTIVE = 2'd3;

   function automatic int opd_desc_width(input int coord_w);
      return OPD_RECT_LSB + 4 * coord_w;
   endfunction

   localparam int OP_DESC_W = opd_desc_width(12);

endpackage

// File: rtl/op_dispatch_fifo.sv
// Small register-based FIFO holding pending op descriptors.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module op_fifo
   import op_dispatch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = OP_DESC_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty && !flush;
   assign do_push = push && (!full || do_pop) && !flush;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         dout   <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            dout   <= mem[rd_ptr];
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/op_dispatch.sv
// Buffers SPI-written operation requests and issues them one at a time to the update
// engine, each aligned to frame_start and held for its programmed number of frames.
module op_dispatch
   import op_dispatch_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int COORD_W = 12
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               csr_en,
   input  logic               csr_op_en,
   input  logic [7:0]         csr_op_cmd,
   input  logic [7:0]         csr_op_param,
   input  logic [7:0]         csr_op_length,
   input  logic [COORD_W-1:0] csr_op_left,
   input  logic [COORD_W-1:0] csr_op_right,
   input  logic [COORD_W-1:0] csr_op_top,
   input  logic [COORD_W-1:0] csr_op_bottom,
   input  logic               frame_start,
   output logic               op_active,
   output logic               op_start,
   output logic               op_done,
   output logic [7:0]         op_cmd,
   output logic [7:0]         op_param,
   output logic [COORD_W-1:0] op_left,
   output logic [COORD_W-1:0] op_right,
   output logic [COORD_W-1:0] op_top,
   output logic [COORD_W-1:0] op_bottom,
   output logic [7:0]         op_frames_left,
   output logic               op_busy,
   output logic               op_queue,
   output logic               op_overflow,
   output logic               op_error
);

   localparam int DESC_W     = opd_desc_width(COORD_W);
   localparam int LEFT_LSB   = OPD_RECT_LSB;
   localparam int RIGHT_LSB  = LEFT_LSB + COORD_W;
   localparam int TOP_LSB    = RIGHT_LSB + COORD_W;
   localparam int BOTTOM_LSB = TOP_LSB + COORD_W;

   logic [1:0]               state;
   logic [DESC_W-1:0]        push_desc;
   logic [DESC_W-1:0]        fifo_dout;
   logic                     fifo_push;
   logic                     fifo_pop;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic [$clog2(DEPTH):0]   fifo_count;
   logic [7:0]               load_cmd;
   logic [7:0]               load_param;
   logic [7:0]               load_len;
   logic [COORD_W-1:0]       load_left;
   logic [COORD_W-1:0]       load_right;
   logic [COORD_W-1:0]       load_top;
   logic [COORD_W-1:0]       load_bottom;
   logic                     load_bad_rect;
   logic [7:0]               cur_len;

   assign push_desc = {csr_op_bottom, csr_op_top, csr_op_right, csr_op_left,
                       csr_op_length, csr_op_param, csr_op_cmd};

   assign fifo_push = csr_op_en && csr_en;
   assign fifo_pop  = (state == OPD_IDLE) && csr_en && !fifo_empty;

   assign load_cmd      = fifo_dout[OPD_CMD_LSB   +: OPD_FIELD_W];
   assign load_param    = fifo_dout[OPD_PARAM_LSB +: OPD_FIELD_W];
   assign load_len      = fifo_dout[OPD_LEN_LSB   +: OPD_FIELD_W];
   assign load_left     = fifo_dout[LEFT_LSB      +: COORD_W];
   assign load_right    = fifo_dout[RIGHT_LSB     +: COORD_W];
   assign load_top      = fifo_dout[TOP_LSB       +: COORD_W];
   assign load_bottom   = fifo_dout[BOTTOM_LSB    +: COORD_W];
   assign load_bad_rect = (load_left > load_right) || (load_top > load_bottom);

   op_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (DESC_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .flush (!csr_en),
      .din   (push_desc),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Dropping csr_en aborts silently: no op_done, and the frame counter is cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= OPD_IDLE;
         op_active      <= 1'b0;
         op_start       <= 1'b0;
         op_done        <= 1'b0;
         op_frames_left <= 8'd0;
      end else begin
         op_start <= 1'b0;
         op_done  <= 1'b0;
         if (!csr_en) begin
            state          <= OPD_IDLE;
            op_active      <= 1'b0;
            op_frames_left <= 8'd0;
         end else begin
            case (state)
               OPD_IDLE: begin
                  if (!fifo_empty) begin
                     state <= OPD_LOAD;
                  end
               end
               OPD_LOAD: begin
                  state <= load_bad_rect ? OPD_IDLE : OPD_ARM;
               end
               OPD_ARM: begin
                  if (frame_start) begin
                     state          <= OPD_ACTIVE;
                     op_active      <= 1'b1;
                     op_start       <= 1'b1;
                     op_frames_left <= cur_len;
                  end
               end
               OPD_ACTIVE: begin
                  if (frame_start) begin
                     if (op_frames_left == 8'd1) begin
                        state          <= OPD_IDLE;
                        op_active      <= 1'b0;
                        op_done        <= 1'b1;
                        op_frames_left <= 8'd0;
                     end else begin
                        op_frames_left <= op_frames_left - 1'b1;
                     end
                  end
               end
               default: state <= OPD_IDLE;
            endcase
         end
      end
   end

   // Descriptor outputs only change on a successful load, so a discarded op leaves them intact.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_cmd    <= 8'd0;
         op_param  <= 8'd0;
         op_left   <= '0;
         op_right  <= '0;
         op_top    <= '0;
         op_bottom <= '0;
         cur_len   <= 8'd0;
      end else if (csr_en && (state == OPD_LOAD) && !load_bad_rect) begin
         op_cmd    <= load_cmd;
         op_param  <= load_param;
         op_left   <= load_left;
         op_right  <= load_right;
         op_top    <= load_top;
         op_bottom <= load_bottom;
         cur_len   <= (load_len == 8'd0) ? 8'd1 : load_len;
      end
   end

   // Status mirrors lag the state and FIFO count by one cycle; sticky flags clear on reset only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_busy     <= 1'b0;
         op_queue    <= 1'b0;
         op_overflow <= 1'b0;
         op_error    <= 1'b0;
      end else begin
         op_busy  <= (state != OPD_IDLE);
         op_queue <= (fifo_count != '0);
         if (fifo_push && fifo_full && !fifo_pop) begin
            op_overflow <= 1'b1;
         end
         if (csr_en && (state == OPD_LOAD) && load_bad_rect) begin
            op_error <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_op_dispatch.sv
// Directed self-checking bench for op_dispatch; inputs change and outputs are sampled on the falling edge.
module tb_op_dispatch;

   localparam int COORD_W = 12;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               csr_en = 1'b0;
   logic               csr_op_en = 1'b0;
   logic [7:0]         csr_op_cmd = '0;
   logic [7:0]         csr_op_param = '0;
   logic [7:0]         csr_op_length = '0;
   logic [COORD_W-1:0] csr_op_left = '0;
   logic [COORD_W-1:0] csr_op_right = '0;
   logic [COORD_W-1:0] csr_op_top = '0;
   logic [COORD_W-1:0] csr_op_bottom = '0;
   logic               frame_start = 1'b0;
   logic               op_active;
   logic               op_start;
   logic               op_done;
   logic [7:0]         op_cmd;
   logic [7:0]         op_param;
   logic [COORD_W-1:0] op_left;
   logic [COORD_W-1:0] op_right;
   logic [COORD_W-1:0] op_top;
   logic [COORD_W-1:0] op_bottom;
   logic [7:0]         op_frames_left;
   logic               op_busy;
   logic               op_queue;
   logic               op_overflow;
   logic               op_error;

   int compared = 0;
   int mismatched = 0;

   op_dispatch #(.DEPTH(4), .COORD_W(COORD_W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .csr_en         (csr_en),
      .csr_op_en      (csr_op_en),
      .csr_op_cmd     (csr_op_cmd),
      .csr_op_param   (csr_op_param),
      .csr_op_length  (csr_op_length),
      .csr_op_left    (csr_op_left),
      .csr_op_right   (csr_op_right),
      .csr_op_top     (csr_op_top),
      .csr_op_bottom  (csr_op_bottom),
      .frame_start    (frame_start),
      .op_active      (op_active),
      .op_start       (op_start),
      .op_done        (op_done),
      .op_cmd         (op_cmd),
      .op_param       (op_param),
      .op_left        (op_left),
      .op_right       (op_right),
      .op_top         (op_top),
      .op_bottom      (op_bottom),
      .op_frames_left (op_frames_left),
      .op_busy        (op_busy),
      .op_queue       (op_queue),
      .op_overflow    (op_overflow),
      .op_error       (op_error)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulseFrame();
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   // One-cycle push; param is always cmd+1 so it can be checked alongside cmd.
   task automatic applyStimulus(input logic [7:0] cmd, input logic [7:0] len,
                                input logic [COORD_W-1:0] l, input logic [COORD_W-1:0] r,
                                input logic [COORD_W-1:0] t, input logic [COORD_W-1:0] b);
      csr_op_cmd    = cmd;
      csr_op_param  = cmd + 8'd1;
      csr_op_length = len;
      csr_op_left   = l;
      csr_op_right  = r;
      csr_op_top    = t;
      csr_op_bottom = b;
      csr_op_en     = 1'b1;
      @(negedge clk);
      csr_op_en     = 1'b0;
   endtask

   initial begin
      step(1);
      checkOutput("rst_active", op_active, 0);
      checkOutput("rst_busy", op_busy, 0);
      checkOutput("rst_queue", op_queue, 0);
      checkOutput("rst_frames", op_frames_left, 0);
      checkOutput("rst_cmd", op_cmd, 0);
      rst_n  = 1'b1;
      csr_en = 1'b1;
      step(1);

      // Basic three-frame op
      applyStimulus(8'h02, 8'd3, 0, 99, 0, 49);
      step(2);
      checkOutput("t1_busy_arm", op_busy, 1);
      checkOutput("t1_no_active_arm", op_active, 0);
      pulseFrame();
      checkOutput("t1_start", op_start, 1);
      checkOutput("t1_active", op_active, 1);
      checkOutput("t1_frames3", op_frames_left, 3);
      checkOutput("t1_cmd", op_cmd, 8'h02);
      checkOutput("t1_param", op_param, 8'h03);
      checkOutput("t1_right", op_right, 99);
      checkOutput("t1_bottom", op_bottom, 49);
      step(1);
      checkOutput("t1_start_pulse", op_start, 0);
      pulseFrame();
      checkOutput("t1_frames2", op_frames_left, 2);
      pulseFrame();
      checkOutput("t1_frames1", op_frames_left, 1);
      checkOutput("t1_no_done_yet", op_done, 0);
      pulseFrame();
      checkOutput("t1_done", op_done, 1);
      checkOutput("t1_active_drop", op_active, 0);
      checkOutput("t1_frames0", op_frames_left, 0);
      step(1);
      checkOutput("t1_done_pulse", op_done, 0);
      checkOutput("t1_idle_busy", op_busy, 0);

      // Overflow while a long op runs, then async reset mid-op
      applyStimulus(8'h10, 8'd200, 0, 10, 0, 10);
      step(2);
      pulseFrame();
      checkOutput("t2_active", op_active, 1);
      checkOutput("t2_frames", op_frames_left, 200);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(8'h11 + 8'(i), 8'd1, 0, 10, 0, 10);
      end
      checkOutput("t2_overflow", op_overflow, 1);
      checkOutput("t2_queue", op_queue, 1);
      checkOutput("t2_still_active", op_active, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("t2_rst_active", op_active, 0);
      checkOutput("t2_rst_overflow", op_overflow, 0);
      checkOutput("t2_rst_queue", op_queue, 0);
      checkOutput("t2_rst_frames", op_frames_left, 0);
      step(1);
      rst_n = 1'b1;
      step(1);
      pulseFrame();
      checkOutput("t2_post_rst_start", op_start, 0);
      checkOutput("t2_post_rst_busy", op_busy, 0);

      // Full FIFO with simultaneous push and pop
      applyStimulus(8'h20, 8'd1, 0, 10, 0, 10);
      step(2);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(8'h21 + 8'(i), 8'd1, 0, 10, 0, 10);
      end
      checkOutput("t3_full_no_overflow", op_overflow, 0);
      pulseFrame();
      checkOutput("t3_startA", op_start, 1);
      checkOutput("t3_cmdA", op_cmd, 8'h20);
      pulseFrame();
      checkOutput("t3_doneA", op_done, 1);
      applyStimulus(8'h25, 8'd1, 0, 10, 0, 10);
      checkOutput("t3_pushpop_no_overflow", op_overflow, 0);
      step(1);
      checkOutput("t3_queue", op_queue, 1);
      for (int i = 0; i < 5; i++) begin
         pulseFrame();
         checkOutput("t3_start", op_start, 1);
         checkOutput("t3_order", op_cmd, 8'h21 + 8'(i));
         pulseFrame();
         checkOutput("t3_done", op_done, 1);
         step(2);
      end
      checkOutput("t3_queue_empty", op_queue, 0);
      checkOutput("t3_busy_end", op_busy, 0);

      // Invalid rectangle is discarded
      applyStimulus(8'h30, 8'd1, 200, 100, 0, 10);
      step(3);
      checkOutput("t4_error", op_error, 1);
      checkOutput("t4_busy", op_busy, 0);
      checkOutput("t4_cmd_held", op_cmd, 8'h25);
      pulseFrame();
      checkOutput("t4_no_start", op_start, 0);
      checkOutput("t4_no_active", op_active, 0);

      // Flush during ACTIVE with two queued ops and a coincident push
      applyStimulus(8'h40, 8'd5, 0, 10, 0, 10);
      step(2);
      pulseFrame();
      checkOutput("t5_active", op_active, 1);
      applyStimulus(8'h41, 8'd1, 0, 10, 0, 10);
      applyStimulus(8'h42, 8'd1, 0, 10, 0, 10);
      step(1);
      checkOutput("t5_queue", op_queue, 1);
      csr_en        = 1'b0;
      csr_op_cmd    = 8'h43;
      csr_op_en     = 1'b1;
      @(negedge clk);
      csr_en    = 1'b1;
      csr_op_en = 1'b0;
      checkOutput("t5_flush_active", op_active, 0);
      checkOutput("t5_flush_done", op_done, 0);
      checkOutput("t5_flush_frames", op_frames_left, 0);
      step(1);
      checkOutput("t5_flush_queue", op_queue, 0);
      checkOutput("t5_flush_busy", op_busy, 0);
      checkOutput("t5_flush_overflow", op_overflow, 0);
      for (int i = 0; i < 3; i++) begin
         pulseFrame();
         checkOutput("t5_quiet_start", op_start, 0);
         checkOutput("t5_quiet_done", op_done, 0);
         checkOutput("t5_quiet_active", op_active, 0);
      end

      // Zero length runs one frame; back-to-back ops are two frame_starts apart
      applyStimulus(8'h50, 8'd0, 0, 10, 0, 10);
      applyStimulus(8'h51, 8'd2, 0, 10, 0, 10);
      step(1);
      pulseFrame();
      checkOutput("t6_startH", op_start, 1);
      checkOutput("t6_cmdH", op_cmd, 8'h50);
      checkOutput("t6_len0_frames", op_frames_left, 1);
      step(1);
      pulseFrame();
      checkOutput("t6_doneH", op_done, 1);
      checkOutput("t6_idle_frame", op_active, 0);
      step(2);
      pulseFrame();
      checkOutput("t6_startI", op_start, 1);
      checkOutput("t6_cmdI", op_cmd, 8'h51);
      checkOutput("t6_framesI", op_frames_left, 2);
      pulseFrame();
      checkOutput("t6_framesI1", op_frames_left, 1);
      pulseFrame();
      checkOutput("t6_doneI", op_done, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
